// File: rtl/computer_top.sv
// computer_top: 8-bit SAP-2-class computer built from a microsequenced CPU, a 4 KiB ROM at F000h,
// a 4 KiB RAM at 0000h, an output port at E000h and an optional 8N1 UART at E008h/E009h.
// Optional UART is built only when the UART_EN macro is defined; otherwise uart_tx idles high.

module computer_rom (
    input  logic        clk,
    input  logic [11:0] addr,
    output logic [7:0]  rdata
);
    logic [7:0] mem [0:4095];

    // Synchronous read, one cycle of latency
    always_ff @(posedge clk) rdata <= mem[addr];

    task automatic init_sim_rom();
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    endtask
    task automatic load(input logic [11:0] a, input logic [7:0] d);
        mem[a] = d;
    endtask
    task automatic dump(input logic [11:0] a, output logic [7:0] d);
        d = mem[a];
    endtask
endmodule

module computer_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata
);
    logic [7:0]  mem [0:4095];
    int unsigned clr_req;
    int unsigned clr_ack;
    logic [11:0] clr_ptr;

    // Zero fill is requested by bumping clr_req; the write port then sweeps one word per clock
    task automatic init_sim_ram();
        clr_req = clr_req + 1;
    endtask
    task automatic dump(input logic [11:0] a, output logic [7:0] d);
        d = mem[a];
    endtask

    // Write port (or background clear) and synchronous read with one cycle of latency
    always_ff @(posedge clk) begin
        if (clr_req != clr_ack) begin
            mem[clr_ptr] <= 8'h00;
            clr_ptr      <= clr_ptr + 12'd1;
            if (clr_ptr == 12'hFFF) clr_ack <= clr_req;
        end else if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

module computer_cpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rdata,
    output logic [15:0] addr,
    output logic [7:0]  wdata,
    output logic        we,
    output logic        rd,
    output logic [7:0]  a_out, b_out, c_out,
    output logic        flag_zero_o, flag_negative_o, flag_carry_o,
    output logic        instr_complete,
    output logic        halted
);
    typedef enum logic [2:0] {FETCH, DECODE, OPR_LO, OPR_HI, MEM, EXEC, HALT} state_t;
    state_t      state;
    logic [15:0] pc;
    logic [7:0]  ir, lo, logic_res;
    logic [8:0]  sum;

    function automatic logic has_imm(input logic [7:0] op);
        return op inside {8'h10, 8'h11, 8'h12, 8'h30, 8'h31, 8'h32};
    endfunction
    function automatic logic has_abs(input logic [7:0] op);
        return op inside {8'h50, 8'h51, 8'h60};
    endfunction

    assign instr_complete = (state == EXEC);
    assign halted         = (state == HALT);

    // ALU: SUB is A + ~B + 1 so carry out means "no borrow"; logic ops take the immediate on rdata
    always_comb begin
        sum = {1'b0, a_out} + {1'b0, (ir == 8'h21) ? c_out : b_out};
        if (ir == 8'h22) sum = {1'b0, a_out} + {1'b0, ~b_out} + 9'd1;
        case (ir[1:0])
            2'd0:    logic_res = a_out & rdata;
            2'd1:    logic_res = a_out | rdata;
            default: logic_res = a_out ^ rdata;
        endcase
    end

    // Bus: PC drives fetches; the absolute address is {hi byte still on rdata, latched lo}
    always_comb begin
        addr  = pc;
        wdata = a_out;
        we    = 1'b0;
        rd    = 1'b0;
        if (state == MEM) begin
            addr = {rdata, lo};
            rd   = 1'b1;
        end else if (state == EXEC && ir == 8'h51) begin
            addr = {rdata, lo};
            we   = 1'b1;
        end else if (state == EXEC && ir == 8'h70) begin
            addr = 16'hE000;
            we   = 1'b1;
        end
    end

    // Microsequencer and architectural state; all instruction results land on the edge ending EXEC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= FETCH;
            pc              <= 16'hF000;
            ir              <= 8'h00;
            lo              <= 8'h00;
            a_out           <= 8'h00;
            b_out           <= 8'h00;
            c_out           <= 8'h00;
            flag_zero_o     <= 1'b0;
            flag_negative_o <= 1'b0;
            flag_carry_o    <= 1'b0;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    ir    <= rdata;
                    pc    <= pc + 16'd1;
                    state <= (has_imm(rdata) || has_abs(rdata)) ? OPR_LO : EXEC;
                end
                OPR_LO: begin
                    pc    <= pc + 16'd1;
                    state <= has_abs(ir) ? OPR_HI : EXEC;
                end
                OPR_HI: begin
                    lo    <= rdata;
                    pc    <= pc + 16'd1;
                    state <= (ir == 8'h50) ? MEM : EXEC;
                end
                MEM:    state <= EXEC;
                EXEC: begin
                    state <= (ir == 8'h01) ? HALT : FETCH;
                    case (ir)
                        8'h10, 8'h50: begin
                            a_out <= rdata; flag_zero_o <= (rdata == 8'h00); flag_negative_o <= rdata[7];
                        end
                        8'h11: begin
                            b_out <= rdata; flag_zero_o <= (rdata == 8'h00); flag_negative_o <= rdata[7];
                        end
                        8'h12: begin
                            c_out <= rdata; flag_zero_o <= (rdata == 8'h00); flag_negative_o <= rdata[7];
                        end
                        8'h20, 8'h21, 8'h22: begin
                            a_out <= sum[7:0]; flag_zero_o <= (sum[7:0] == 8'h00);
                            flag_negative_o <= sum[7]; flag_carry_o <= sum[8];
                        end
                        8'h30, 8'h31, 8'h32: begin
                            a_out <= logic_res; flag_zero_o <= (logic_res == 8'h00);
                            flag_negative_o <= logic_res[7]; flag_carry_o <= 1'b0;
                        end
                        8'h40:   flag_carry_o <= 1'b1;
                        8'h41:   flag_carry_o <= 1'b0;
                        8'h60:   pc <= {rdata, lo};
                        default: ;
                    endcase
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

module computer_top #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int CLK_FREQ_HZ = 20_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] output_port_1,
    input  logic                  uart_rx,
    output logic                  uart_tx
);
    typedef enum logic [1:0] {SEL_IO, SEL_RAM, SEL_ROM} sel_t;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata, cpu_rdata, ram_rdata, rom_rdata, io_q, io_next;
    logic                  bus_we, bus_rd, cpu_instr_complete, cpu_halted;
    sel_t                  sel_q;

    computer_cpu u_cpu (
        .clk(clk), .reset(reset), .rdata(cpu_rdata), .addr(bus_addr), .wdata(bus_wdata),
        .we(bus_we), .rd(bus_rd), .a_out(), .b_out(), .c_out(), .flag_zero_o(),
        .flag_negative_o(), .flag_carry_o(), .instr_complete(cpu_instr_complete), .halted(cpu_halted)
    );
    computer_rom u_rom (.clk(clk), .addr(bus_addr[11:0]), .rdata(rom_rdata));
    computer_ram u_ram (.clk(clk), .we(bus_we && bus_addr[15:12] == 4'h0), .addr(bus_addr[11:0]),
                        .wdata(bus_wdata), .rdata(ram_rdata));

    // Remember which region the last address hit so the read mux lines up with memory latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q <= SEL_IO;
            io_q  <= '0;
        end else begin
            sel_q <= (bus_addr[15:12] == 4'h0) ? SEL_RAM : (bus_addr[15:12] == 4'hF) ? SEL_ROM : SEL_IO;
            io_q  <= io_next;
        end
    end

    always_comb begin
        case (sel_q)
            SEL_RAM: cpu_rdata = ram_rdata;
            SEL_ROM: cpu_rdata = rom_rdata;
            default: cpu_rdata = io_q;
        endcase
    end

    // Output port latches A on OUT or any store to E000h
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            output_port_1 <= '0;
        else if (bus_we && bus_addr == 16'hE000) output_port_1 <= bus_wdata;
    end

`ifdef UART_EN
    localparam logic [15:0] DIV_M1 = 16'(CLK_FREQ_HZ / BAUD_RATE - 1);
    localparam logic [15:0] HALF   = 16'(CLK_FREQ_HZ / BAUD_RATE / 2);
    logic [15:0] tx_cnt, rx_cnt;
    logic [3:0]  tx_bits, rx_bits;
    logic [9:0]  tx_shift;
    logic [7:0]  rx_shift, rx_data;
    logic [1:0]  rx_sync;
    logic        tx_busy, rx_busy, rx_valid;

    assign uart_tx = tx_shift[0];
    assign io_next = (bus_addr == 16'hE008) ? rx_data :
                     (bus_addr == 16'hE009) ? {6'b0, rx_valid, tx_busy} : '0;

    // Transmitter: frame {stop, data, start} on a write to E008h, shift out LSB first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_busy <= 1'b0; tx_shift <= '1; tx_cnt <= '0; tx_bits <= '0;
        end else if (!tx_busy) begin
            if (bus_we && bus_addr == 16'hE008) begin
                tx_shift <= {1'b1, bus_wdata, 1'b0}; tx_busy <= 1'b1; tx_cnt <= '0; tx_bits <= '0;
            end
        end else if (tx_cnt == DIV_M1) begin
            tx_cnt   <= '0;
            tx_shift <= {1'b1, tx_shift[9:1]};
            if (tx_bits == 4'd9) tx_busy <= 1'b0;
            else                 tx_bits <= tx_bits + 4'd1;
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end

    // Receiver: sample mid-bit after a start edge; a read of E008h consumes the byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync <= '1; rx_busy <= 1'b0; rx_cnt <= '0; rx_bits <= '0;
            rx_shift <= '0; rx_data <= '0; rx_valid <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
            if (bus_rd && bus_addr == 16'hE008) rx_valid <= 1'b0;
            if (!rx_busy) begin
                if (!rx_sync[1]) begin rx_busy <= 1'b1; rx_cnt <= HALF; rx_bits <= '0; end
            end else if (rx_cnt == DIV_M1) begin
                rx_cnt  <= '0;
                rx_bits <= rx_bits + 4'd1;
                if (rx_bits == 4'd0) begin
                    if (rx_sync[1]) rx_busy <= 1'b0;
                end else if (rx_bits == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_sync[1]) begin rx_data <= rx_shift; rx_valid <= 1'b1; end
                end else begin
                    rx_shift <= {rx_sync[1], rx_shift[7:1]};
                end
            end else begin
                rx_cnt <= rx_cnt + 16'd1;
            end
        end
    end
`else
    localparam int unused_div = CLK_FREQ_HZ / BAUD_RATE;
    logic unused_in;
    assign unused_in = ^{uart_rx, bus_rd, cpu_halted};
    assign uart_tx   = 1'b1;
    assign io_next   = '0;
`endif
endmodule

// File: tb/tb_computer_top.sv
// Bench for computer_top: directed programs plus random programs checked against an
// instruction-level reference interpreter (state, cycle count and outputs per instruction).
module tb_computer_top;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] output_port_1;
    logic       uart_tx;
    int vectors = 0, miscompares = 0;
    int rom_img [4096];
    int ram_m [4096];
    int prog [$];
    int ma, mb, mc, mz, mn, mcy, mpc, mout, mhalt;

    computer_top dut (.clk(clk), .reset(reset), .output_port_1(output_port_1),
                      .uart_rx(uart_rx), .uart_tx(uart_tx));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dut_state();
        return {29'd0, dut.u_cpu.a_out, dut.u_cpu.b_out, dut.u_cpu.c_out, dut.u_cpu.flag_zero_o,
                dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o, output_port_1};
    endfunction
    function automatic logic [63:0] model_state();
        return {29'd0, 8'(ma), 8'(mb), 8'(mc), 1'(mz), 1'(mn), 1'(mcy), 8'(mout)};
    endfunction

    function automatic int mem_rd(input int a);
        if (a < 4096)    return ram_m[a];
        if (a >= 'hF000) return rom_img[a - 'hF000];
        return 0;
    endfunction

    // Reference interpreter: one whole instruction, returns expected cycle count
    task automatic step_model(output int cyc);
        int op, r, ad;
        op = mem_rd(mpc); mpc = (mpc + 1) % 65536; cyc = 3;
        case (op)
            'h01: mhalt = 1;
            'h10, 'h11, 'h12: begin
                r = mem_rd(mpc); mpc = (mpc + 1) % 65536; cyc = 4;
                if (op == 'h10) ma = r; else if (op == 'h11) mb = r; else mc = r;
                mz = (r == 0); mn = (r >= 128);
            end
            'h20, 'h21: begin
                r = ma + ((op == 'h20) ? mb : mc);
                ma = r % 256; mcy = (r > 255); mz = (ma == 0); mn = (ma >= 128);
            end
            'h22: begin
                mcy = (ma >= mb); ma = (ma - mb + 256) % 256; mz = (ma == 0); mn = (ma >= 128);
            end
            'h30, 'h31, 'h32: begin
                r = mem_rd(mpc); mpc = (mpc + 1) % 65536; cyc = 4;
                ma = (op == 'h30) ? (ma & r) : (op == 'h31) ? (ma | r) : (ma ^ r);
                mcy = 0; mz = (ma == 0); mn = (ma >= 128);
            end
            'h40: mcy = 1;
            'h41: mcy = 0;
            'h50, 'h51, 'h60: begin
                ad = mem_rd(mpc) + 256 * mem_rd((mpc + 1) % 65536);
                mpc = (mpc + 2) % 65536; cyc = 5;
                if (op == 'h50) begin
                    ma = mem_rd(ad); mz = (ma == 0); mn = (ma >= 128); cyc = 6;
                end else if (op == 'h51) begin
                    if (ad < 4096) ram_m[ad] = ma;
                    if (ad == 'hE000) mout = ma;
                end else mpc = ad;
            end
            'h70: mout = ma;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; mc = 0; mz = 0; mn = 0; mcy = 0; mpc = 'hF000; mout = 0; mhalt = 0;
    endtask

    task automatic load_prog();
        @(negedge clk); reset = 1'b0;
        dut.u_rom.init_sim_rom();
        for (int i = 0; i < 4096; i++) rom_img[i] = 0;
        foreach (prog[i]) begin
            rom_img[i] = prog[i];
            dut.u_rom.load(12'(i), 8'(prog[i]));
        end
    endtask

    // Counts cycles from the current one until cpu_instr_complete is seen (bounded)
    task automatic wait_complete(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk); cyc++;
            if (dut.cpu_instr_complete === 1'b1) break;
            if (cyc > 20) begin cyc = 999; break; end
        end
    endtask

    task automatic run_program(input string name);
        int cyc, exp_cyc, n, extra;
        model_reset();
        @(posedge clk); #1 reset = 1'b1;
        n = 0;
        while (mhalt == 0 && n < 200) begin
            step_model(exp_cyc);
            wait_complete(cyc);
            check({name, ".cycles"}, 64'(cyc), 64'(exp_cyc));
            @(posedge clk); #1;
            check({name, ".state"}, dut_state(), model_state());
            n++;
        end
        check({name, ".halted"}, 64'(dut.u_cpu.halted), 64'd1);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (dut.cpu_instr_complete !== 1'b0) extra++;
        end
        check({name, ".no_complete_after_hlt"}, 64'(extra), 64'd0);
    endtask

    function automatic int rand_byte();
        case ($urandom_range(0, 5))
            0: return 'h00;
            1: return 'hFF;
            2: return 'h80;
            3: return 'h7F;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic gen_random();
        int ops [16] = '{'h00, 'h10, 'h11, 'h12, 'h20, 'h21, 'h22, 'h30,
                         'h31, 'h32, 'h40, 'h41, 'h50, 'h51, 'h60, 'h70};
        int op, ad, base;
        prog = {};
        repeat (30) begin
            op = ops[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0) op = 'h99;
            base = prog.size();
            prog.push_back(op);
            if (op inside {'h10, 'h11, 'h12, 'h30, 'h31, 'h32}) prog.push_back(rand_byte());
            else if (op == 'h50) begin
                case ($urandom_range(0, 3))
                    0: ad = 'hF000 + int'($urandom_range(0, 15));
                    1: ad = ($urandom_range(0, 1) == 1) ? 'hE009 : 'h8000;
                    default: ad = int'($urandom_range(0, 15));
                endcase
                prog.push_back(ad % 256); prog.push_back(ad / 256);
            end else if (op == 'h51) begin
                ad = ($urandom_range(0, 4) == 0) ? 'hE000 : int'($urandom_range(0, 15));
                prog.push_back(ad % 256); prog.push_back(ad / 256);
            end else if (op == 'h60) begin
                ad = 'hF000 + base + 4;
                prog.push_back(ad % 256); prog.push_back(ad / 256);
                prog.push_back('h01);
            end
        end
        prog.push_back('h01);
    endtask

    initial begin
        int cyc;
        dut.u_ram.init_sim_ram();
        for (int i = 0; i < 4096; i++) ram_m[i] = 0;
        repeat (4100) @(posedge clk);
        #1;
        check("reset.regs", dut_state(), 64'd0);
        check("reset.pc", 64'(dut.u_cpu.pc), 64'hF000);
        check("reset.ctrl", {61'd0, uart_tx, dut.cpu_instr_complete, dut.u_cpu.halted}, 64'b100);

        prog = '{'h10, 'hFF, 'h11, 'h01, 'h20, 'h41, 'h01};
        load_prog(); run_program("add_wrap");
        check("add_wrap.final", {56'd0, dut.u_cpu.a_out}, 64'h00);
        check("add_wrap.flags", {61'd0, dut.u_cpu.flag_zero_o, dut.u_cpu.flag_negative_o,
                                 dut.u_cpu.flag_carry_o}, 64'b100);

        prog = '{'h10, 'h80, 'h11, 'h42, 'h12, 'hAA, 'h40, 'h41, 'h01};
        load_prog(); run_program("sec_clc");

        prog = '{'h10, 'h55, 'h30, 'h55, 'h41, 'h40, 'h41, 'h41, 'h41, 'h01};
        load_prog(); run_program("ani_clc");

        prog = '{'h10, 'h7F, 'h11, 'h01, 'h20, 'h40, 'h41, 'h01};
        load_prog(); run_program("add_ovf");
        check("add_ovf.final", {53'd0, dut.u_cpu.a_out, dut.u_cpu.flag_zero_o,
                                dut.u_cpu.flag_negative_o, dut.u_cpu.flag_carry_o}, {53'd0, 8'h80, 3'b010});

        prog = '{'h10, 'h05, 'h11, 'h05, 'h22, 'h11, 'h06, 'h22, 'h51, 'h03, 'h00,
                 'h10, 'h00, 'h50, 'h03, 'h00, 'h01};
        load_prog(); run_program("sub_mem");

        prog = '{'h10, 'h5A, 'h70, 'h01};
        load_prog(); run_program("out_hlt");
        check("out_hlt.port", 64'(output_port_1), 64'h5A);

        // Reset during the cycle before ADD's EXEC must abort it and restart from F000h
        prog = '{'h10, 'hFF, 'h11, 'h01, 'h20, 'h41, 'h01};
        load_prog();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) begin
            wait_complete(cyc);
            @(posedge clk); #1;
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst.regs", dut_state(), 64'd0);
        check("midrst.pc", 64'(dut.u_cpu.pc), 64'hF000);
        @(posedge clk); #1;
        check("midrst.no_exec", {55'd0, dut.cpu_instr_complete, dut.u_cpu.a_out}, 64'd0);
        run_program("midrst.restart");

        for (int p = 0; p < 4; p++) begin
            gen_random();
            load_prog();
            run_program($sformatf("rand%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
